// File: rtl/mm_arbiter_if.sv
// rtl/mm_arbiter_if.sv - request/response and multiplier bus of mm_arbiter
//
// Bundles the requester side (req_*/rsp_*), the status flag (busy) and the
// multiplier side (mm_*) of the arbiter.
//   slave  : arbiter view (drives req_ready, rsp_*, busy, mm_start, mm_a/b/m)
//   master : environment view (drives req_valid, req_a/b/m, mm_p, mm_ready)
// Operand vectors are flattened; requester i occupies bits [i*W +: W].
interface mm_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 256
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [N_REQ*W-1:0] req_m;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [W-1:0]       rsp_p;
    logic               rsp_err;
    logic               busy;
    logic               mm_start;
    logic [W-1:0]       mm_a;
    logic [W-1:0]       mm_b;
    logic [W-1:0]       mm_m;
    logic [W-1:0]       mm_p;
    logic               mm_ready;

    modport slave (
        input  req_valid, req_a, req_b, req_m, mm_p, mm_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p, rsp_err, busy,
               mm_start, mm_a, mm_b, mm_m
    );

    modport master (
        output req_valid, req_a, req_b, req_m, mm_p, mm_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p, rsp_err, busy,
               mm_start, mm_a, mm_b, mm_m
    );
endinterface

// File: rtl/mm_arbiter.sv
// rtl/mm_arbiter.sv - round-robin arbiter/sequencer for one shared modular multiplier
//
// Ports:
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    mm_arbiter_if.slave
//          req_valid/req_a/req_b/req_m in, req_ready out (one-hot accept)
//          rsp_valid/rsp_id/rsp_p/rsp_err out (one-cycle response strobe)
//          busy out, mm_start/mm_a/mm_b/mm_m out, mm_p/mm_ready in
//
// One operation at a time: IDLE (grant + latch operands) -> ISSUE (start
// pulse) -> WAIT (multiplier or watchdog) -> RESP (strobe, advance pointer).
module mm_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mm_arbiter_if.slave   bus
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_gnt;
    logic [WDW-1:0]     r_wdog;
    logic               r_mm_start;
    logic [W-1:0]       r_mm_a;
    logic [W-1:0]       r_mm_b;
    logic [W-1:0]       r_mm_m;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [W-1:0]       r_rsp_p;
    logic               r_rsp_err;

    logic               w_any;
    logic [IDW-1:0]     w_gnt;
    logic [N_REQ-1:0]   w_gnt_oh;
    logic [W-1:0]       w_a;
    logic [W-1:0]       w_b;
    logic [W-1:0]       w_m;
    logic [IDW-1:0]     w_next_ptr;

    // First requester at or after r_rr_ptr, wrapping past N_REQ-1.
    always_comb begin : grant_search
        logic [IDW:0] sum;
        sum   = '0;
        w_any = 1'b0;
        w_gnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, r_rr_ptr} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(N_REQ)) begin
                sum = sum - (IDW+1)'(N_REQ);
            end
            if (!w_any && bus.req_valid[sum[IDW-1:0]]) begin
                w_any = 1'b1;
                w_gnt = sum[IDW-1:0];
            end
        end
    end

    // Operand mux with constant slice bases, plus the one-hot grant vector.
    always_comb begin
        w_a      = '0;
        w_b      = '0;
        w_m      = '0;
        w_gnt_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDW'(i) == w_gnt) begin
                w_a         = bus.req_a[i*W +: W];
                w_b         = bus.req_b[i*W +: W];
                w_m         = bus.req_m[i*W +: W];
                w_gnt_oh[i] = w_any;
            end
        end
    end

    assign w_next_ptr = (r_gnt == IDW'(N_REQ - 1)) ? '0 : r_gnt + IDW'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_gnt       <= '0;
            r_wdog      <= '0;
            r_mm_start  <= 1'b0;
            r_mm_a      <= '0;
            r_mm_b      <= '0;
            r_mm_m      <= '0;
            r_rsp_valid <= '0;
            r_rsp_id    <= '0;
            r_rsp_p     <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        // Operands stay frozen until the next acceptance; the
                        // multiplier keeps reading them while it iterates.
                        r_mm_a     <= w_a;
                        r_mm_b     <= w_b;
                        r_mm_m     <= w_m;
                        r_gnt      <= w_gnt;
                        r_mm_start <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mm_start <= 1'b0;
                    r_wdog     <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    // A ready pulse wins over the watchdog limit in the same cycle.
                    if (bus.mm_ready) begin
                        r_rsp_p     <= bus.mm_p;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= ONE << r_gnt;
                        r_rsp_id    <= r_gnt;
                        r_state     <= S_RESP;
                    end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
                        r_rsp_p     <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= ONE << r_gnt;
                        r_rsp_id    <= r_gnt;
                        r_state     <= S_RESP;
                    end else begin
                        r_wdog <= r_wdog + WDW'(1);
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= '0;
                    r_rr_ptr    <= w_next_ptr;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Acceptance is a same-cycle handshake, so req_ready and busy are decoded
    // from the current state; reset forces them low like every other output.
    assign bus.req_ready = (r_state == S_IDLE && !i_rst) ? w_gnt_oh : '0;
    assign bus.busy      = !i_rst && ((r_state != S_IDLE) || w_any);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_p     = r_rsp_p;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.mm_start  = r_mm_start;
    assign bus.mm_a      = r_mm_a;
    assign bus.mm_b      = r_mm_b;
    assign bus.mm_m      = r_mm_m;
endmodule

// File: tb/tb_mm_arbiter.sv
// tb/tb_mm_arbiter.sv - self-checking bench for mm_arbiter
module tb_mm_arbiter;
    localparam int N = 4;
    localparam int W = 256;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mm_arbiter_if #(.N_REQ(N), .W(W)) bus ();
    mm_arbiter_if #(.N_REQ(N), .W(W)) bus2 ();

    mm_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(1023)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus)
    );
    mm_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(16)) dut_to (
        .i_clk(clk), .i_rst(rst), .bus(bus2)
    );

    function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b,
                                            input logic [255:0] m);
        logic [511:0] t;
        t = {256'd0, a} * {256'd0, b};
        t = t % {256'd0, m};
        return t[255:0];
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Multiplier model: mm_ready 257 cycles after the start cycle; product
    // taken from the operands as they stand late in the operation.
    int           mcnt;
    logic [255:0] mp;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt <= 0;
            mp   <= '0;
        end else begin
            if (bus.mm_start) mcnt <= 257;
            else if (mcnt > 0) mcnt <= mcnt - 1;
            if (mcnt == 2) mp <= mulmod(bus.mm_a, bus.mm_b, bus.mm_m);
        end
    end
    assign bus.mm_ready = (mcnt == 1);
    assign bus.mm_p     = mp;

    logic         to_ready;
    logic [255:0] to_p;
    assign bus2.mm_ready = to_ready;
    assign bus2.mm_p     = to_p;

    typedef struct {
        int           id;
        logic [255:0] p;
        logic         err;
        int           cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic push_exp(input int id, input logic [255:0] p, input logic err, input int c);
        exp_t e;
        e.id = id; e.p = p; e.err = err; e.cyc = c;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && (|bus.rsp_valid)) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_rsp: rsp_valid=%b id=%0d, none required", bus.rsp_valid, bus.rsp_id);
            end else begin
                mon_e = sb.pop_front();
                total++;
                if (bus.rsp_valid !== (N'(1) << mon_e.id) || bus.rsp_id !== 2'(mon_e.id)) begin
                    bad++;
                    $display("FAIL rsp_id: valid=%b id=%0d, required id %0d", bus.rsp_valid, bus.rsp_id, mon_e.id);
                end
                total++;
                if (bus.rsp_p !== mon_e.p) begin
                    bad++;
                    $display("FAIL rsp_p: got %h required %h", bus.rsp_p, mon_e.p);
                end
                total++;
                if (bus.rsp_err !== mon_e.err) begin
                    bad++;
                    $display("FAIL rsp_err: got %b required %b", bus.rsp_err, mon_e.err);
                end
                total++;
                if (cyc != mon_e.cyc) begin
                    bad++;
                    $display("FAIL rsp_cycle: got %0d required %0d", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int limit, output logic ok, output int t);
        ok = 1'b0;
        t  = -1;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (|bus.req_ready) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        drive_edge();
        rst = 1'b1;
        repeat (2) drive_edge();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [255:0] a, input logic [255:0] b, input logic [255:0] m);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_m[i*W +: W] = m;
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        set_req(0, 256'd9, 256'd9, 256'd11);
        repeat (3) drive_edge();
        @(negedge clk);
        total++;
        if (bus.req_ready !== 4'b0 || bus.busy !== 1'b0 || bus.mm_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: req_ready=%b busy=%b mm_start=%b, required all 0", bus.req_ready, bus.busy, bus.mm_start);
        end
        total++;
        if (bus.rsp_valid !== 4'b0 || bus.rsp_id !== 2'd0 || bus.rsp_err !== 1'b0 || bus.rsp_p !== 256'd0) begin
            bad++;
            $display("FAIL reset_rsp: valid=%b id=%0d err=%b p=%h, required 0", bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_p);
        end
        total++;
        if (bus.mm_a !== 256'd0 || bus.mm_b !== 256'd0 || bus.mm_m !== 256'd0) begin
            bad++;
            $display("FAIL reset_operands: mm_a=%h mm_b=%h mm_m=%h, required 0", bus.mm_a, bus.mm_b, bus.mm_m);
        end
        drive_edge();
        bus.req_valid = '0;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 4'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b req_ready=%b, required 0", bus.busy, bus.req_ready);
        end
    endtask

    task automatic test_single();
        logic ok;
        int   t, t0;
        drive_edge();
        set_req(0, 256'd3, 256'd5, 256'd7);
        bus.req_valid = 4'b0001;
        t0 = cyc;
        wait_accept(5, ok, t);
        total++;
        if (!ok || t != t0 || bus.req_ready !== 4'b0001 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL single_accept: ok=%b cycle=%0d ready=%b busy=%b, required cycle %0d ready 0001 busy 1", ok, t, bus.req_ready, bus.busy, t0);
        end
        push_exp(0, 256'd1, 1'b0, t + 259);
        drive_edge();
        bus.req_valid = '0;
        @(negedge clk);
        total++;
        if (bus.mm_start !== 1'b1 || bus.mm_a !== 256'd3 || bus.mm_b !== 256'd5 || bus.mm_m !== 256'd7) begin
            bad++;
            $display("FAIL single_issue: mm_start=%b a=%0d b=%0d m=%0d, required 1 3 5 7", bus.mm_start, bus.mm_a, bus.mm_b, bus.mm_m);
        end
        @(negedge clk);
        total++;
        if (bus.mm_start !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL single_start_pulse: mm_start=%b busy=%b, required 0 1", bus.mm_start, bus.busy);
        end
        drain(400);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL single_drain: %0d responses outstanding, required 0", sb.size());
        end
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: busy=%b at cycle %0d, required 0", bus.busy, cyc);
        end
    endtask

    task automatic run_sequence(input string name, input int nacc, input int order[4],
                                input logic [255:0] ea[4], input logic [255:0] eb[4],
                                input logic [255:0] em[4]);
        logic ok;
        int   t, tp;
        tp = -1;
        for (int k = 0; k < nacc; k++) begin
            wait_accept(300, ok, t);
            total++;
            if (!ok || bus.req_ready !== (N'(1) << order[k]) || (tp >= 0 && t != tp + 260)) begin
                bad++;
                $display("FAIL %s_grant%0d: ok=%b ready=%b cycle=%0d, required ready bit %0d at %0d", name, k, ok, bus.req_ready, t, order[k], tp + 260);
            end
            push_exp(order[k], mulmod(ea[order[k]], eb[order[k]], em[order[k]]), 1'b0, t + 259);
            tp = t;
            drive_edge();
            if (k == nacc - 1) bus.req_valid = '0;
            else if (name == "simul") bus.req_valid[order[k]] = 1'b0;
        end
        drain(400);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d responses outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic gen_ops(output logic [255:0] ea[4], output logic [255:0] eb[4], output logic [255:0] em[4]);
        for (int i = 0; i < 4; i++) begin
            em[i] = rnd256() | {1'b1, 255'd0} | 256'd1;
            ea[i] = rnd256() % em[i];
            eb[i] = rnd256() % em[i];
            set_req(i, ea[i], eb[i], em[i]);
        end
    endtask

    task automatic test_simultaneous();
        logic [255:0] ea[4], eb[4], em[4];
        int           order[4];
        do_reset();
        order = '{0, 1, 2, 3};
        gen_ops(ea, eb, em);
        bus.req_valid = 4'b1111;
        run_sequence("simul", 4, order, ea, eb, em);
    endtask

    task automatic test_fairness();
        logic [255:0] ea[4], eb[4], em[4];
        int           order[4];
        drive_edge();
        order = '{1, 3, 1, 3};
        gen_ops(ea, eb, em);
        bus.req_valid = 4'b1010;
        run_sequence("fair", 4, order, ea, eb, em);
    endtask

    task automatic test_operand_hold();
        logic [255:0] a, b, m;
        logic         ok;
        int           t, chg;
        drive_edge();
        m = rnd256() | {1'b1, 255'd0} | 256'd1;
        a = rnd256() % m;
        b = rnd256() % m;
        set_req(0, a, b, m);
        bus.req_valid = 4'b0001;
        wait_accept(5, ok, t);
        total++;
        if (!ok || bus.req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL hold_accept: ok=%b ready=%b, required 0001", ok, bus.req_ready);
        end
        push_exp(0, mulmod(a, b, m), 1'b0, t + 259);
        drive_edge();
        bus.req_valid = '0;
        set_req(0, ~a, b ^ 256'h5a5a, m);
        chg = 0;
        for (int i = 0; i < 257; i++) begin
            @(negedge clk);
            if (bus.mm_a !== a || bus.mm_b !== b || bus.mm_m !== m) chg++;
        end
        total++;
        if (chg != 0) begin
            bad++;
            $display("FAIL hold_operands: operands differed from accepted values in %0d cycles, required 0", chg);
        end
        drain(400);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL hold_drain: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_timeout();
        int           t, rc, spur;
        logic         ok, r_err;
        logic [3:0]   r_v;
        logic [1:0]   r_id;
        logic [255:0] r_p;
        logic [255:0] x;
        drive_edge();
        bus2.req_a[2*W +: W] = 256'd4;
        bus2.req_b[2*W +: W] = 256'd6;
        bus2.req_m[2*W +: W] = 256'd13;
        bus2.req_valid = 4'b0100;
        ok = 1'b0; t = -1;
        for (int i = 0; i < 5 && !ok; i++) begin
            @(negedge clk);
            if (|bus2.req_ready) begin ok = 1'b1; t = cyc; end
        end
        drive_edge();
        bus2.req_valid = '0;
        rc = -1; r_v = '0; r_id = '0; r_p = '1; r_err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rc < 0 && (|bus2.rsp_valid)) begin
                rc = cyc; r_v = bus2.rsp_valid; r_id = bus2.rsp_id; r_p = bus2.rsp_p; r_err = bus2.rsp_err;
            end
        end
        total++;
        if (!ok || rc != t + 18 || r_v !== 4'b0100 || r_id !== 2'd2) begin
            bad++;
            $display("FAIL timeout_when: ok=%b rsp cycle=%0d valid=%b id=%0d, required cycle %0d valid 0100 id 2", ok, rc, r_v, r_id, t + 18);
        end
        total++;
        if (r_err !== 1'b1 || r_p !== 256'd0) begin
            bad++;
            $display("FAIL timeout_value: err=%b p=%h, required err 1 p 0", r_err, r_p);
        end
        drive_edge();
        to_ready = 1'b1;
        to_p = 256'hdead;
        drive_edge();
        to_ready = 1'b0;
        spur = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((|bus2.rsp_valid) || bus2.busy) spur++;
        end
        total++;
        if (spur != 0) begin
            bad++;
            $display("FAIL spurious_ready: %0d cycles with rsp_valid or busy, required 0", spur);
        end
        // ready exactly at the watchdog limit must count as success
        drive_edge();
        bus2.req_valid = 4'b0010;
        ok = 1'b0; t = -1;
        for (int i = 0; i < 5 && !ok; i++) begin
            @(negedge clk);
            if (|bus2.req_ready) begin ok = 1'b1; t = cyc; end
        end
        total++;
        if (!ok || bus2.req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL limit_accept: ok=%b ready=%b, required 0010", ok, bus2.req_ready);
        end
        drive_edge();
        bus2.req_valid = '0;
        for (int i = 0; i < 40 && cyc < t + 17; i++) drive_edge();
        x = rnd256();
        to_p = x;
        to_ready = 1'b1;
        drive_edge();
        to_ready = 1'b0;
        @(negedge clk);
        total++;
        if (cyc != t + 18 || bus2.rsp_valid !== 4'b0010 || bus2.rsp_err !== 1'b0 || bus2.rsp_p !== x) begin
            bad++;
            $display("FAIL limit_success: cycle=%0d valid=%b err=%b p=%h, required cycle %0d valid 0010 err 0 p %h", cyc, bus2.rsp_valid, bus2.rsp_err, bus2.rsp_p, t + 18, x);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic ok;
        int   t;
        drive_edge();
        set_req(2, 256'd10, 256'd12, 256'd17);
        bus.req_valid = 4'b0100;
        wait_accept(5, ok, t);
        total++;
        if (!ok || bus.req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL rstwait_accept: ok=%b ready=%b, required 0100", ok, bus.req_ready);
        end
        drive_edge();
        bus.req_valid = '0;
        for (int i = 0; i < 200 && cyc < t + 100; i++) drive_edge();
        rst = 1'b1;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.mm_start !== 1'b0 || bus.mm_a !== 256'd0 || bus.mm_b !== 256'd0 ||
            bus.rsp_valid !== 4'b0 || bus.req_ready !== 4'b0) begin
            bad++;
            $display("FAIL rstwait_outputs: busy=%b start=%b a=%h b=%h valid=%b, required all 0", bus.busy, bus.mm_start, bus.mm_a, bus.mm_b, bus.rsp_valid);
        end
        repeat (3) drive_edge();
        rst = 1'b0;
        drive_edge();
        set_req(0, 256'd8, 256'd9, 256'd23);
        set_req(1, 256'd2, 256'd2, 256'd5);
        bus.req_valid = 4'b0011;
        wait_accept(5, ok, t);
        total++;
        if (!ok || bus.req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL rstwait_rr_ptr: ok=%b ready=%b, required 0001", ok, bus.req_ready);
        end
        push_exp(0, 256'd3, 1'b0, t + 259);
        drive_edge();
        bus.req_valid = '0;
        drain(400);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL rstwait_drain: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        #(10 * 20000);
        $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
        $fatal(1, "bench stalled");
    end

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_m = '0;
        bus2.req_valid = '0;
        bus2.req_a = '0;
        bus2.req_b = '0;
        bus2.req_m = '0;
        to_ready = 1'b0;
        to_p = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_operand_hold();
        test_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
